fetch_queue: RTL

Instruction buffer on the consuming side of the fetch PC generator. Accepts 4-wide fetch groups (PC, instruction word, prediction bit per lane) from the fetch stage and presents up to 4 oldest instructions per cycle to decode. Drives `stall_pc` back to the PC generator as the backpressure that holds the fetch address. Cleared by any pipeline redirect.

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_queue_if.sv | 34 +++
 rtl/fetch_queue_popcount4.sv | 12 +
 rtl/fetch_queue.sv | 78 +++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: lane count, entry layout, boot PC.
package fetch_queue_pkg;

  localparam int unsigned FETCH_WIDTH = 4;
  localparam logic [31:0] START_PC    = 32'h1c00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle for the fetch queue.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                              enq_valid;
  logic [FETCH_WIDTH-1:0]            enq_mask;
  logic [FETCH_WIDTH-1:0][31:0]      enq_pc;
  logic [FETCH_WIDTH-1:0][31:0]      enq_inst;
  logic [FETCH_WIDTH-1:0]            enq_pred;
  logic                              stall_pc;
  logic [FETCH_WIDTH-1:0]            deq_valid;
  logic [FETCH_WIDTH-1:0][31:0]      deq_pc;
  logic [FETCH_WIDTH-1:0][31:0]      deq_inst;
  logic [FETCH_WIDTH-1:0]            deq_pred;
  logic [2:0]                        deq_accept;
  logic [CW-1:0]                     count;

  // Fetch stage / decode stage side.
  modport master (
    output enq_valid, enq_mask, enq_pc, enq_inst, enq_pred, deq_accept,
    input  stall_pc, deq_valid, deq_pc, deq_inst, deq_pred, count
  );

  // Queue side.
  modport slave (
    input  enq_valid, enq_mask, enq_pc, enq_inst, enq_pred, deq_accept,
    output stall_pc, deq_valid, deq_pc, deq_inst, deq_pred, count
  );

endinterface

// File: rtl/fetch_queue_popcount4.sv
// Number of set bits in a 4-lane valid mask.
module fq_popcount4 (
  input  logic [3:0] mask,
  output logic [2:0] cnt
);

  // Plain adder tree; mask is small enough that no sharing is needed.
  always_comb begin
    cnt = 3'(mask[0]) + 3'(mask[1]) + 3'(mask[2]) + 3'(mask[3]);
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch PC generation and decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned FW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  fetch_queue_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fq_entry_t         mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [CW-1:0]     cnt;
  logic [2:0]        mask_cnt;
  logic [2:0]        n_enq;
  logic [2:0]        n_deq;
  logic              stall;
  logic              enq_fire;

  fq_popcount4 u_popcount (
    .mask (bus.enq_mask),
    .cnt  (mask_cnt)
  );

  // Backpressure from registered occupancy only; released during a redirect.
  always_comb begin
    stall    = !flush && ((int'(DEPTH) - int'(cnt)) < int'(FW));
    enq_fire = bus.enq_valid && !stall && !flush && !rst;
    n_enq    = enq_fire ? mask_cnt : 3'd0;
    n_deq    = flush ? 3'd0 : bus.deq_accept;
  end

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + AW'(n_deq);
      tail <= tail + AW'(n_enq);
      cnt  <= cnt + CW'(n_enq) - CW'(n_deq);
    end
  end

  // Entry storage; lane i of an accepted group lands at tail + i.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FW; i++) begin
      if (enq_fire && bus.enq_mask[i]) begin
        mem[tail + AW'(i)] <= '{pc: bus.enq_pc[i], inst: bus.enq_inst[i], pred: bus.enq_pred[i]};
      end
    end
  end

  // Decode view: the oldest FW entries starting at head, registered data only.
  always_comb begin
    bus.stall_pc  = stall;
    bus.count     = cnt;
    bus.deq_valid = '0;
    bus.deq_pc    = '0;
    bus.deq_inst  = '0;
    bus.deq_pred  = '0;
    for (int unsigned i = 0; i < FW; i++) begin
      bus.deq_valid[i] = (cnt > CW'(i));
      bus.deq_pc[i]    = mem[head + AW'(i)].pc;
      bus.deq_inst[i]  = mem[head + AW'(i)].inst;
      bus.deq_pred[i]  = mem[head + AW'(i)].pred;
    end
  end

endmodule
